// File: rtl/genshin_pipe_pkg.sv
// Shared pipeline opcodes and the store lane-placement helper.
// Used by the EX->MEM register and the store-history decode.
package genshin_pipe_pkg;

  localparam int WORD_W = 32;
  localparam int LANES  = WORD_W / 8;

  localparam logic [7:0] EXE_NOP_OP   = 8'h00;
  localparam logic [7:0] EXE_SB_OP    = 8'hE8;
  localparam logic [7:0] EXE_SH_OP    = 8'hE9;
  localparam logic [7:0] EXE_SW_OP    = 8'hEB;
  localparam logic [4:0] NOP_REG_ADDR = 5'h00;

  typedef struct packed {
    logic              is_store;
    logic              misaligned;
    logic [LANES-1:0]  ben;
    logic [WORD_W-1:0] data;
  } store_lane_t;

  // Places raw store data onto its little-endian byte lanes within the word.
  function automatic store_lane_t store_lane(input logic [7:0]        op,
                                             input logic [1:0]        a,
                                             input logic [WORD_W-1:0] d);
    store_lane_t r;
    r = '0;
    case (op)
      EXE_SB_OP: begin
        r.is_store = 1'b1;
        r.ben      = 4'b0001 << a;
        r.data     = {24'h0, d[7:0]} << {a, 3'b000};
      end
      EXE_SH_OP: begin
        r.is_store = 1'b1;
        if (a[0]) begin
          r.misaligned = 1'b1;
        end else begin
          r.ben  = 4'b0011 << {a[1], 1'b0};
          r.data = {16'h0, d[15:0]} << {a[1], 4'b0000};
        end
      end
      EXE_SW_OP: begin
        r.is_store = 1'b1;
        if (a != 2'b00) begin
          r.misaligned = 1'b1;
        end else begin
          r.ben  = 4'hF;
          r.data = d;
        end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/store_hist_buf.sv
// Circular history of the last DEPTH stores; combinational per-byte lookup, youngest wins.
// Write/invalidate take effect next cycle; no backpressure, a full buffer overwrites oldest.
module store_hist_buf #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear_i,
  input  logic                wr_i,
  input  logic                inv_i,
  input  logic [ADDR_W-3:0]   waddr_i,
  input  logic [DATA_W/8-1:0] ben_i,
  input  logic [DATA_W-1:0]   data_i,
  input  logic [ADDR_W-3:0]   lk_waddr_i,
  output logic [DATA_W-1:0]   lk_data_o,
  output logic [DATA_W/8-1:0] lk_bmask_o,
  output logic [CNT_W-1:0]    count_o
);

  localparam int LANES = DATA_W / 8;
  localparam int WA_W  = ADDR_W - 2;
  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0][WA_W-1:0]   waddr_q, waddr_d;
  logic [DEPTH-1:0][LANES-1:0]  ben_q, ben_d;
  logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
  logic [PTR_W-1:0]             wptr_q, wptr_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic [PTR_W-1:0]             idx;

  // Clear is applied before invalidate/record so a same-cycle store lands in slot 0.
  always_comb begin
    valid_d = valid_q;
    waddr_d = waddr_q;
    ben_d   = ben_q;
    data_d  = data_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (clear_i) begin
      valid_d = '0;
      wptr_d  = '0;
      count_d = '0;
    end
    if (inv_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_d[i] && (waddr_q[i] == waddr_i)) valid_d[i] = 1'b0;
      end
    end
    if (wr_i) begin
      valid_d[wptr_d] = 1'b1;
      waddr_d[wptr_d] = waddr_i;
      ben_d[wptr_d]   = ben_i;
      data_d[wptr_d]  = data_i;
      wptr_d          = wptr_d + PTR_W'(1);
      if (count_d != CNT_W'(DEPTH)) count_d = count_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      waddr_q <= '0;
      ben_q   <= '0;
      data_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      waddr_q <= waddr_d;
      ben_q   <= ben_d;
      data_q  <= data_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Walk oldest (slot at wptr) to youngest so younger hits overwrite older ones.
  always_comb begin
    lk_data_o  = '0;
    lk_bmask_o = '0;
    idx        = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = wptr_q + PTR_W'(k);
      if (valid_q[idx] && (waddr_q[idx] == lk_waddr_i)) begin
        for (int l = 0; l < LANES; l++) begin
          if (ben_q[idx][l]) begin
            lk_bmask_o[l]       = 1'b1;
            lk_data_o[8*l +: 8] = data_q[idx][8*l +: 8];
          end
        end
      end
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/ex_mem_fwd_buf.sv
// EX->MEM pipeline register (1 cycle) with stall/bubble/flush, plus store-history forwarding.
// No backpressure of its own: stall_cur/stall_nxt from hazard logic hold or bubble the stage.
module ex_mem_fwd_buf
  import genshin_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int RA_W   = 5,
  parameter int OP_W   = 8,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall_cur,
  input  logic                         stall_nxt,
  input  logic                         flush,
  input  logic                         sb_clear,
  input  logic [RA_W-1:0]              ex_wd,
  input  logic                         ex_wreg,
  input  logic [DATA_W-1:0]            ex_wdata,
  input  logic [OP_W-1:0]              ex_aluop,
  input  logic [ADDR_W-1:0]            ex_mem_addr,
  input  logic [DATA_W-1:0]            ex_reg2,
  output logic [RA_W-1:0]              mem_wd,
  output logic                         mem_wreg,
  output logic [DATA_W-1:0]            mem_wdata,
  output logic [OP_W-1:0]              mem_aluop,
  output logic [ADDR_W-1:0]            mem_mem_addr,
  output logic [DATA_W-1:0]            mem_reg2,
  input  logic [ADDR_W-1:0]            lk_addr,
  output logic [DATA_W-1:0]            lk_data,
  output logic [DATA_W/8-1:0]          lk_bmask,
  output logic [$clog2(DEPTH+1)-1:0]   sb_count
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [RA_W-1:0]   mem_wd_q, mem_wd_d;
  logic              mem_wreg_q, mem_wreg_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [OP_W-1:0]   mem_aluop_q, mem_aluop_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_reg2_q, mem_reg2_d;

  logic        capture;
  logic        bubble;
  store_lane_t sl;
  logic        lk_lane_unused;

  assign bubble  = flush || (stall_cur && !stall_nxt);
  assign capture = !flush && !stall_cur;

  always_comb begin
    mem_wd_d    = mem_wd_q;
    mem_wreg_d  = mem_wreg_q;
    mem_wdata_d = mem_wdata_q;
    mem_aluop_d = mem_aluop_q;
    mem_addr_d  = mem_addr_q;
    mem_reg2_d  = mem_reg2_q;
    if (bubble) begin
      mem_wd_d    = RA_W'(NOP_REG_ADDR);
      mem_wreg_d  = 1'b0;
      mem_wdata_d = '0;
      mem_aluop_d = OP_W'(EXE_NOP_OP);
      mem_addr_d  = '0;
      mem_reg2_d  = '0;
    end else if (capture) begin
      mem_wd_d    = ex_wd;
      mem_wreg_d  = ex_wreg;
      mem_wdata_d = ex_wdata;
      mem_aluop_d = ex_aluop;
      mem_addr_d  = ex_mem_addr;
      mem_reg2_d  = ex_reg2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_wd_q    <= RA_W'(NOP_REG_ADDR);
      mem_wreg_q  <= 1'b0;
      mem_wdata_q <= '0;
      mem_aluop_q <= OP_W'(EXE_NOP_OP);
      mem_addr_q  <= '0;
      mem_reg2_q  <= '0;
    end else begin
      mem_wd_q    <= mem_wd_d;
      mem_wreg_q  <= mem_wreg_d;
      mem_wdata_q <= mem_wdata_d;
      mem_aluop_q <= mem_aluop_d;
      mem_addr_q  <= mem_addr_d;
      mem_reg2_q  <= mem_reg2_d;
    end
  end

  assign mem_wd       = mem_wd_q;
  assign mem_wreg     = mem_wreg_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_aluop    = mem_aluop_q;
  assign mem_mem_addr = mem_addr_q;
  assign mem_reg2     = mem_reg2_q;

  // Only stores actually entering MEM touch the history; misaligned ones poison their word.
  assign sl = store_lane(8'(ex_aluop), ex_mem_addr[1:0], WORD_W'(ex_reg2));

  // Lookups are word granular; the byte offset of the load does not matter.
  assign lk_lane_unused = ^lk_addr[1:0];

  store_hist_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_hist (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (sb_clear),
    .wr_i       (capture && sl.is_store && !sl.misaligned),
    .inv_i      (capture && sl.is_store && sl.misaligned),
    .waddr_i    (ex_mem_addr[ADDR_W-1:2]),
    .ben_i      ((DATA_W/8)'(sl.ben)),
    .data_i     (DATA_W'(sl.data)),
    .lk_waddr_i (lk_addr[ADDR_W-1:2]),
    .lk_data_o  (lk_data),
    .lk_bmask_o (lk_bmask),
    .count_o    (sb_count)
  );

endmodule

// File: tb/tb_ex_mem_fwd_buf.sv
// Directed bench for ex_mem_fwd_buf: queue-based reference model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_ex_mem_fwd_buf;
  import genshin_pipe_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, stall_cur, stall_nxt, flush, sb_clear;
  logic [4:0]  ex_wd, mem_wd;
  logic        ex_wreg, mem_wreg;
  logic [31:0] ex_wdata, mem_wdata, ex_mem_addr, mem_mem_addr, ex_reg2, mem_reg2;
  logic [7:0]  ex_aluop, mem_aluop;
  logic [31:0] lk_addr, lk_data;
  logic [3:0]  lk_bmask;
  logic [2:0]  sb_count;

  always #5 clk = ~clk;

  ex_mem_fwd_buf #(.DATA_W(32), .ADDR_W(32), .RA_W(5), .OP_W(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .stall_cur(stall_cur), .stall_nxt(stall_nxt), .flush(flush),
    .sb_clear(sb_clear), .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_aluop(mem_aluop),
    .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2), .lk_addr(lk_addr),
    .lk_data(lk_data), .lk_bmask(lk_bmask), .sb_count(sb_count)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit        v;
    bit [29:0] wa;
    bit [3:0]  ben;
    bit [31:0] d;
  } ent_t;

  ent_t        hist[$];
  int          m_cnt;
  logic [4:0]  m_wd;
  logic        m_wreg;
  logic [31:0] m_wdata, m_addr, m_reg2;
  logic [7:0]  m_aluop;

  task automatic m_nop();
    m_wd = 5'd0; m_wreg = 1'b0; m_wdata = 32'd0;
    m_aluop = EXE_NOP_OP; m_addr = 32'd0; m_reg2 = 32'd0;
  endtask

  task automatic m_record(input logic [7:0] op, input logic [31:0] a, input logic [31:0] r2);
    int        lane;
    bit        mis;
    bit [3:0]  ben;
    bit [31:0] d;
    ent_t      e;
    lane = int'(a % 4);
    mis  = 1'b0;
    ben  = 4'h0;
    d    = 32'h0;
    if (op == EXE_SB_OP) begin
      ben = 4'b0001 << lane;
      d   = (r2 & 32'hFF) << (8 * lane);
    end else if (op == EXE_SH_OP) begin
      if (lane % 2 != 0) mis = 1'b1;
      else begin
        ben = 4'b0011 << lane;
        d   = (r2 & 32'hFFFF) << (8 * lane);
      end
    end else if (op == EXE_SW_OP) begin
      if (lane != 0) mis = 1'b1;
      else begin
        ben = 4'hF;
        d   = r2;
      end
    end else begin
      return;
    end
    if (mis) begin
      foreach (hist[i]) if (hist[i].wa == a[31:2]) hist[i].v = 1'b0;
    end else begin
      e.v = 1'b1; e.wa = a[31:2]; e.ben = ben; e.d = d;
      hist.push_back(e);
      if (hist.size() > DEPTH) void'(hist.pop_front());
      if (m_cnt < DEPTH) m_cnt++;
    end
  endtask

  task automatic m_edge();
    if (rst) begin
      m_nop();
      hist.delete();
      m_cnt = 0;
    end else begin
      if (flush || (stall_cur && !stall_nxt)) m_nop();
      else if (!stall_cur) begin
        m_wd = ex_wd; m_wreg = ex_wreg; m_wdata = ex_wdata;
        m_aluop = ex_aluop; m_addr = ex_mem_addr; m_reg2 = ex_reg2;
      end
      if (sb_clear) begin
        hist.delete();
        m_cnt = 0;
      end
      if (!flush && !stall_cur) m_record(ex_aluop, ex_mem_addr, ex_reg2);
    end
  endtask

  task automatic m_look(input logic [31:0] a, output logic [31:0] d, output logic [3:0] m);
    d = 32'h0;
    m = 4'h0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i].v && hist[i].wa == a[31:2]) begin
        for (int l = 0; l < 4; l++) begin
          if (!m[l] && hist[i].ben[l]) begin
            m[l] = 1'b1;
            d[8*l +: 8] = hist[i].d[8*l +: 8];
          end
        end
      end
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    logic [31:0] ed;
    logic [3:0]  em;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        m_look(lk_addr, ed, em);
        cmp("mem_wd",       32'(mem_wd),       32'(m_wd));
        cmp("mem_wreg",     32'(mem_wreg),     32'(m_wreg));
        cmp("mem_wdata",    mem_wdata,         m_wdata);
        cmp("mem_aluop",    32'(mem_aluop),    32'(m_aluop));
        cmp("mem_mem_addr", mem_mem_addr,      m_addr);
        cmp("mem_reg2",     mem_reg2,          m_reg2);
        cmp("lk_data",      lk_data,           ed);
        cmp("lk_bmask",     32'(lk_bmask),     32'(em));
        cmp("sb_count",     32'(sb_count),     32'(m_cnt));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic idle();
    stall_cur = 1'b0; stall_nxt = 1'b0; flush = 1'b0; sb_clear = 1'b0;
    ex_wd = 5'd0; ex_wreg = 1'b0; ex_wdata = 32'd0;
    ex_aluop = EXE_NOP_OP; ex_mem_addr = 32'd0; ex_reg2 = 32'd0;
  endtask

  task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] r2);
    ex_wd = 5'd9; ex_wreg = 1'b1; ex_wdata = r2;
    ex_aluop = op; ex_mem_addr = a; ex_reg2 = r2;
  endtask

  task automatic store(input logic [7:0] op, input logic [31:0] a, input logic [31:0] r2);
    issue(op, a, r2);
    step();
    idle();
  endtask

  task automatic look(input logic [31:0] a);
    lk_addr = a;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    lk_addr = 32'd0;
    step();
    step();
    chk_en = 1'b1;
    cmp("rst_aluop", 32'(mem_aluop), 32'h00);
    cmp("rst_count", 32'(sb_count), 32'd0);
    cmp("rst_mask",  32'(lk_bmask), 32'h0);
    rst = 1'b0;

    // 1 capture
    issue(EXE_SW_OP, 32'h100, 32'hDEADBEEF);
    step();
    idle();
    look(32'h100);
    cmp("t1_aluop", 32'(mem_aluop), 32'hEB);
    cmp("t1_wd",    32'(mem_wd), 32'd9);
    cmp("t1_addr",  mem_mem_addr, 32'h100);
    cmp("t1_wdata", mem_wdata, 32'hDEADBEEF);
    cmp("t1_lk",    lk_data, 32'hDEADBEEF);
    cmp("t1_mask",  32'(lk_bmask), 32'hF);
    cmp("t1_count", 32'(sb_count), 32'd1);

    // 2 byte merge
    store(EXE_SW_OP, 32'h200, 32'h11223344);
    store(EXE_SB_OP, 32'h203, 32'h000000AA);
    look(32'h200);
    cmp("t2_merge", lk_data, 32'hAA223344);
    cmp("t2_mask",  32'(lk_bmask), 32'hF);
    store(EXE_SB_OP, 32'h205, 32'h00000055);
    look(32'h204);
    cmp("t2_sb_data", lk_data, 32'h00005500);
    cmp("t2_sb_mask", 32'(lk_bmask), 32'h2);
    cmp("t2_count",   32'(sb_count), 32'd4);

    // 3 bubble / hold / flush
    sb_clear = 1'b1;
    step();
    sb_clear = 1'b0;
    cmp("t3_clr", 32'(sb_count), 32'd0);
    store(EXE_SW_OP, 32'h600, 32'h12345678);
    issue(EXE_SW_OP, 32'h500, 32'h0BADF00D);
    stall_cur = 1'b1; stall_nxt = 1'b0;
    step();
    cmp("t3_bub_op",   32'(mem_aluop), 32'h00);
    cmp("t3_bub_wreg", 32'(mem_wreg), 32'd0);
    cmp("t3_bub_cnt",  32'(sb_count), 32'd1);
    stall_cur = 1'b0;
    store(EXE_SB_OP, 32'h601, 32'h0000009A);
    cmp("t3_sb_cnt", 32'(sb_count), 32'd2);
    issue(EXE_SW_OP, 32'h700, 32'h1);
    stall_cur = 1'b1; stall_nxt = 1'b1;
    step();
    cmp("t3_hold_op",   32'(mem_aluop), 32'hE8);
    cmp("t3_hold_addr", mem_mem_addr, 32'h601);
    cmp("t3_hold_cnt",  32'(sb_count), 32'd2);
    stall_cur = 1'b0; stall_nxt = 1'b0;
    flush = 1'b1;
    step();
    idle();
    cmp("t3_flush_op",  32'(mem_aluop), 32'h00);
    cmp("t3_flush_cnt", 32'(sb_count), 32'd2);

    // 4 wrap
    sb_clear = 1'b1;
    step();
    sb_clear = 1'b0;
    for (int i = 0; i <= DEPTH; i++) store(EXE_SW_OP, 32'(i * 4), 32'(i + 1));
    look(32'h0);
    cmp("t4_old_mask", 32'(lk_bmask), 32'h0);
    look(32'h10);
    cmp("t4_new_data", lk_data, 32'h5);
    cmp("t4_new_mask", 32'(lk_bmask), 32'hF);
    cmp("t4_count",    32'(sb_count), 32'd4);

    // 5 misaligned invalidate, clear with same-cycle record
    sb_clear = 1'b1;
    step();
    sb_clear = 1'b0;
    store(EXE_SW_OP, 32'h300, 32'hCAFEF00D);
    store(EXE_SH_OP, 32'h301, 32'h0000BEEF);
    look(32'h300);
    cmp("t5_mis_mask", 32'(lk_bmask), 32'h0);
    issue(EXE_SB_OP, 32'h400, 32'h00000077);
    sb_clear = 1'b1;
    step();
    idle();
    look(32'h400);
    cmp("t5_count", 32'(sb_count), 32'd1);
    cmp("t5_mask",  32'(lk_bmask), 32'h1);
    cmp("t5_data",  lk_data, 32'h77);

    // 6 reset mid-stream
    store(EXE_SW_OP, 32'h800, 32'h1111);
    store(EXE_SW_OP, 32'h804, 32'h2222);
    store(EXE_SB_OP, 32'h808, 32'h33);
    issue(EXE_SW_OP, 32'h80C, 32'h4444);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    look(32'h800);
    cmp("t6_count", 32'(sb_count), 32'd0);
    cmp("t6_mask",  32'(lk_bmask), 32'h0);
    cmp("t6_aluop", 32'(mem_aluop), 32'h00);

    step();
    step();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
